regfile_mp: RTL

- Parametrised multi-port integer register file; successor of the single-write, two-read core register file.
- Configurable width, depth, read-port count and write-port count.
- Same-cycle write-to-read bypass per port.
- Hardware clear sequencer: zeroes the array after reset or on request; array is not cleared in a single cycle.
- Per-register pending scoreboard for the issue stage: reserve at issue, release at writeback.

---
 rtl/regfile_mp.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
// Parametrised multi-port integer register file with same-cycle write-to-read
// bypass, a hardware clear sequencer and a per-register pending scoreboard.
//
// After reset (or a clear request) the array is zeroed one register per clock
// by the clear sequencer; ready stays low until every register has been
// cleared. While clearing, reads return 0 and writes/reservations are ignored.
//
// Ports:
//   clk        clock
//   rst        synchronous reset, active-low
//   clear_req  pulse, restarts the clear sequence (only honoured when ready)
//   ready      1 = array initialised and accepting writes (registered)
//   rd_en      per-port read enable                     [NUM_RD]
//   rd_addr    packed read addresses, port i at [i*AW +: AW]
//   rd_data    packed read data, combinational, port i at [i*XLEN +: XLEN]
//   rd_busy    per-port: addressed register has an outstanding reservation
//   wr_en      per-port write enable                    [NUM_WR]
//   wr_addr    packed write addresses
//   wr_data    packed write data
//   rsv_en     reserve rsv_addr (destination issued)
//   rsv_addr   register to mark pending
// -----------------------------------------------------------------------------
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int AW       = $clog2(NUM_REGS),
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear_req,
  output logic                   ready,
  input  logic [NUM_RD-1:0]      rd_en,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  output logic [NUM_RD-1:0]      rd_busy,
  input  logic [NUM_WR-1:0]      wr_en,
  input  logic [NUM_WR*AW-1:0]   wr_addr,
  input  logic [NUM_WR*XLEN-1:0] wr_data,
  input  logic                   rsv_en,
  input  logic [AW-1:0]          rsv_addr
);

  localparam logic ST_INIT = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);

  logic                state_q, state_d;
  logic [AW-1:0]       clr_idx_q, clr_idx_d;
  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [XLEN-1:0]     regs_q [NUM_REGS];
  logic [XLEN-1:0]     regs_d [NUM_REGS];

  // A write port commits only in RUN, out of reset, not on a clear edge,
  // and never to the hard-wired zero register.
  logic [NUM_WR-1:0]   wr_commit_s;

  // True when addr names the hard-wired zero register.
  function automatic logic is_zero_reg(input logic [AW-1:0] addr);
    return (ZERO_REG != 0) && (addr == {AW{1'b0}});
  endfunction

  assign ready = (state_q == ST_RUN);

  // Per-port write commit qualification.
  always_comb begin
    wr_commit_s = {NUM_WR{1'b0}};
    for (int j = 0; j < NUM_WR; j++) begin
      wr_commit_s[j] = rst && (state_q == ST_RUN) && !clear_req && wr_en[j] &&
                       !is_zero_reg(wr_addr[j*AW +: AW]);
    end
  end

  // Combinational read ports with bypass from the highest committing writer.
  always_comb begin
    logic [AW-1:0]   ra_v;
    logic            hit_v;
    logic [XLEN-1:0] byp_v;
    rd_data = {(NUM_RD*XLEN){1'b0}};
    rd_busy = {NUM_RD{1'b0}};
    ra_v    = {AW{1'b0}};
    hit_v   = 1'b0;
    byp_v   = {XLEN{1'b0}};
    for (int i = 0; i < NUM_RD; i++) begin
      ra_v  = rd_addr[i*AW +: AW];
      hit_v = 1'b0;
      byp_v = {XLEN{1'b0}};
      // Ascending scan so the highest matching port is the one left standing.
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_commit_s[j] && (wr_addr[j*AW +: AW] == ra_v)) begin
          hit_v = 1'b1;
          byp_v = wr_data[j*XLEN +: XLEN];
        end else begin
          byp_v = byp_v;
        end
      end
      if (!rst || (state_q == ST_INIT) || !rd_en[i] || is_zero_reg(ra_v)) begin
        rd_data[i*XLEN +: XLEN] = {XLEN{1'b0}};
        rd_busy[i]              = 1'b0;
      end else if (hit_v) begin
        // The in-flight write is the value the consumer wants, so not busy.
        rd_data[i*XLEN +: XLEN] = byp_v;
        rd_busy[i]              = 1'b0;
      end else begin
        rd_data[i*XLEN +: XLEN] = regs_q[ra_v];
        rd_busy[i]              = pending_q[ra_v];
      end
    end
  end

  // Next-state logic: reset, clear sequencer, writes and scoreboard.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    pending_d = pending_q;
    regs_d    = regs_q;
    if (!rst) begin
      state_d   = ST_INIT;
      clr_idx_d = {AW{1'b0}};
      pending_d = {NUM_REGS{1'b0}};
    end else if (state_q == ST_INIT) begin
      regs_d[clr_idx_q] = {XLEN{1'b0}};
      // NUM_REGS is a power of two, so the index wraps back to 0 on exit.
      clr_idx_d = clr_idx_q + AW'(1);
      if (clr_idx_q == LAST_IDX) begin
        state_d = ST_RUN;
      end else begin
        state_d = ST_INIT;
      end
    end else if (clear_req) begin
      state_d   = ST_INIT;
      clr_idx_d = {AW{1'b0}};
      pending_d = {NUM_REGS{1'b0}};
    end else begin
      // Ascending order: a higher port to the same address overwrites.
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_commit_s[j]) begin
          regs_d[wr_addr[j*AW +: AW]]    = wr_data[j*XLEN +: XLEN];
          pending_d[wr_addr[j*AW +: AW]] = 1'b0;
        end else begin
          pending_d = pending_d;
        end
      end
      // Applied after the write releases so a new reservation wins.
      if (rsv_en && !is_zero_reg(rsv_addr)) begin
        pending_d[rsv_addr] = 1'b1;
      end else begin
        pending_d = pending_d;
      end
    end
  end

  // Control state, clear index and scoreboard registers.
  always_ff @(posedge clk) begin
    state_q   <= state_d;
    clr_idx_q <= clr_idx_d;
    pending_q <= pending_d;
  end

  // Register array storage; contents are only ever cleared by the sequencer.
  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

endmodule
